conv3_job_sequencer: RTL and testbench

Host-side controller that runs one complete job on the 3x3 convolution memory engine (the 14-bit-address, 32-bit-word register/RAM window).
- Streams LOAD_WORDS input words (activations plus packed weights) into engine RAM.
- Writes the start register, then polls the done register.
- Reads OUTPUT_POINT result words and returns them on an output valid/ready stream.
- Sits between a DMA/AXI-stream source and the engine, so software never has to bit-bang engine addresses.

---
 rtl/conv3_job_sequencer.sv | 172 +++++++++++++++++
 tb/tb_conv3_job_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3_job_sequencer.sv
// Host-side job sequencer for the 3x3 convolution engine: load RAM, kick start, poll done, drain results.
// Optional poll watchdog is compiled in with `define CONV3_SEQ_TIMEOUT_EN.
module conv3_job_sequencer #(
  parameter int VALID_ADDR_WIDTH = 14,
  parameter int DATA_WIDTH       = 32,
  parameter int LOAD_WORDS       = 216,
  parameter int OUTPUT_POINT     = 2,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_job_start,
  output logic                        o_busy,
  output logic                        o_job_done,
  output logic                        o_error,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [DATA_WIDTH-1:0]       i_in_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [DATA_WIDTH-1:0]       o_out_data,
  output logic                        o_mem_we,
  output logic [VALID_ADDR_WIDTH-1:0] o_mem_write_addr,
  output logic [DATA_WIDTH-1:0]       o_mem_wdata,
  output logic                        o_mem_re,
  output logic [VALID_ADDR_WIDTH-1:0] o_mem_read_addr,
  input  logic [DATA_WIDTH-1:0]       i_mem_rdata
);

  localparam int LCW = $clog2(LOAD_WORDS + 1);
  localparam int RCW = $clog2(OUTPUT_POINT + 1);
  localparam logic [VALID_ADDR_WIDTH-1:0] DONE_ADDR   = '1;
  localparam logic [VALID_ADDR_WIDTH-1:0] START_ADDR  = {{(VALID_ADDR_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [VALID_ADDR_WIDTH-1:0] RESULT_BASE = VALID_ADDR_WIDTH'(LOAD_WORDS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_POLL  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]            state;
  logic [LCW-1:0]        load_cnt;
  logic [RCW-1:0]        rd_cnt;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  load_hs;
  logic                  done_seen;
  logic                  drain_issue;
  logic                  out_hs;
  logic                  timeout_hit;

  assign load_hs     = (state == S_LOAD) && i_in_valid;
  assign done_seen   = (state == S_POLL) && i_mem_rdata[0];
  assign drain_issue = (state == S_DRAIN) && !out_valid;
  assign out_hs      = out_valid && i_out_ready;

`ifdef CONV3_SEQ_TIMEOUT_EN
  localparam int PCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [PCW-1:0] poll_cnt;
  logic           error;

  // The last permitted poll is the one seen with poll_cnt == TIMEOUT_CYCLES-1.
  assign timeout_hit = (state == S_POLL) && !i_mem_rdata[0] &&
                       (poll_cnt == PCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      poll_cnt <= '0;
      error    <= 1'b0;
    end else begin
      if (state == S_WAIT)
        poll_cnt <= '0;
      else if (state == S_POLL)
        poll_cnt <= poll_cnt + 1'b1;
      if ((state == S_IDLE) && i_job_start)
        error <= 1'b0;
      else if (timeout_hit)
        error <= 1'b1;
    end
  end

  assign o_error = error;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign o_error        = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_job_start) begin
          state    <= S_LOAD;
          load_cnt <= '0;
        end
        S_LOAD: if (load_hs) begin
          load_cnt <= load_cnt + 1'b1;
          if (load_cnt == LCW'(LOAD_WORDS - 1)) state <= S_START;
        end
        S_START: state <= S_WAIT;
        S_WAIT:  state <= S_POLL;
        S_POLL: begin
          if (done_seen) begin
            state  <= S_DRAIN;
            rd_cnt <= '0;
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end
        end
        // A read is only issued while the output register is empty, so results cost two cycles each.
        S_DRAIN: begin
          if (drain_issue) begin
            out_data  <= i_mem_rdata;
            out_valid <= 1'b1;
          end else if (out_hs) begin
            out_valid <= 1'b0;
            rd_cnt    <= rd_cnt + 1'b1;
            if (rd_cnt == RCW'(OUTPUT_POINT - 1)) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_mem_we         = 1'b0;
    o_mem_write_addr = '0;
    o_mem_wdata      = '0;
    o_mem_re         = 1'b0;
    o_mem_read_addr  = '0;
    case (state)
      S_LOAD: begin
        o_mem_we         = i_in_valid;
        o_mem_write_addr = VALID_ADDR_WIDTH'(load_cnt);
        o_mem_wdata      = i_in_data;
      end
      S_START: begin
        o_mem_we         = 1'b1;
        o_mem_write_addr = START_ADDR;
        o_mem_wdata      = DATA_WIDTH'(1);
      end
      S_POLL: begin
        o_mem_re        = 1'b1;
        o_mem_read_addr = DONE_ADDR;
      end
      S_DRAIN: if (!out_valid) begin
        o_mem_re        = 1'b1;
        o_mem_read_addr = RESULT_BASE + VALID_ADDR_WIDTH'(rd_cnt);
      end
      default: ;
    endcase
  end

  assign o_busy      = (state != S_IDLE);
  assign o_in_ready  = (state == S_LOAD);
  assign o_job_done  = (state == S_DONE);
  assign o_out_valid = out_valid;
  assign o_out_data  = out_data;

endmodule

// File: tb/tb_conv3_job_sequencer.sv
// Bench for conv3_job_sequencer: behavioural engine + stream scoreboard with randomized traffic.
// With CONV3_SEQ_TIMEOUT_EN defined, the watchdog path is exercised with TIMEOUT_CYCLES=16.
module tb_conv3_job_sequencer;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int LW = 216;
  localparam int OP = 2;
`ifdef CONV3_SEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam logic [AW-1:0] START_A = 14'h3FFE;
  localparam logic [AW-1:0] DONE_A  = 14'h3FFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic job_start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic busy, job_done, error, in_ready, out_valid, mem_we, mem_re;
  logic [DW-1:0] out_data, mem_wdata, mem_rdata;
  logic [AW-1:0] waddr, raddr;

  conv3_job_sequencer #(
    .VALID_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_WORDS(LW),
    .OUTPUT_POINT(OP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_job_start(job_start),
    .o_busy(busy), .o_job_done(job_done), .o_error(error),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_mem_we(mem_we), .o_mem_write_addr(waddr), .o_mem_wdata(mem_wdata),
    .o_mem_re(mem_re), .o_mem_read_addr(raddr), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req_v);
    end
  endtask

  // Engine model: RAM, start register, done flag that rises eng_delay cycles after start and clears on read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic eng_done = 1'b0;
  int   eng_timer = 0;
  int   eng_delay = 6;
  bit   eng_hang = 1'b0;

  assign mem_rdata = (raddr == DONE_A) ? {31'b0, eng_done} : mem[raddr];

  function automatic logic [DW-1:0] ram_sum();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < LW; i++) s += mem[i];
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_done  <= 1'b0;
      eng_timer <= 0;
    end else begin
      if (mem_we && waddr != START_A) mem[waddr] <= mem_wdata;
      if (mem_we && waddr == START_A && mem_wdata == 32'd1) begin
        mem[LW]   <= ram_sum();
        mem[LW+1] <= mem[LW-1] + 32'd1;
        if (!eng_hang) eng_timer <= eng_delay;
      end else if (eng_timer > 0) begin
        eng_timer <= eng_timer - 1;
        if (eng_timer == 1) eng_done <= 1'b1;
      end
      if (mem_re && raddr == DONE_A && eng_done) eng_done <= 1'b0;
    end
  end

  // Result consumer: always ready, random, or a 5-cycle stall on the first valid of the job.
  int ready_mode = 0;
  int hold_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode != 2) hold_cnt = 0;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && hold_cnt < 5) begin
          out_ready = 1'b0;
          hold_cnt++;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  // Reference: job source words, and expected results derived from them.
  logic [DW-1:0] src [0:LW-1];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got [0:31];
  int got_n = 0, wr_idx = 0, start_wr = 0, res_k = 0, poll_rd = 0;
  int done_total = 0, last_writes = 0, last_starts = 0;
  int req = 0, tmo_cnt = 0, jobs_exp = 0;
  logic probe = 1'b0;
  logic p_valid = 1'b0, p_ready = 1'b0, p_done = 1'b0, p_error = 1'b0;
  logic [DW-1:0] p_data = '0;

  function automatic logic [DW-1:0] src_sum();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < LW; i++) s += src[i];
    return s;
  endfunction

  always @(negedge clk or posedge probe) begin
    if (probe) begin
      check("async_rst_ctrl", 32'({busy, job_done, error, in_ready, out_valid, mem_we, mem_re}), 32'd0);
      check("async_rst_bus", 32'(|{out_data, mem_wdata, waddr, raddr}), 32'd0);
    end else if (!rst_n) begin
      check("rst_ctrl", 32'({busy, job_done, error, in_ready, out_valid, mem_we, mem_re}), 32'd0);
      check("rst_bus", 32'(|{out_data, mem_wdata, waddr, raddr}), 32'd0);
      exp_q.delete();
      wr_idx = 0; start_wr = 0; res_k = 0; poll_rd = 0;
      p_valid = 1'b0; p_ready = 1'b0; p_done = 1'b0; p_error = 1'b0;
    end else begin
      check("we_re_excl", 32'(mem_we & mem_re), 32'd0);
      check("busy_cover", 32'((mem_we | mem_re | out_valid | job_done | in_ready) & ~busy), 32'd0);
`ifndef CONV3_SEQ_TIMEOUT_EN
      check("error_tied", 32'(error), 32'd0);
`endif
      if (p_done) check("idle_after_done", 32'({busy, in_ready}), 32'd0);
      if (in_valid && in_ready) check("write_on_hs", 32'(mem_we), 32'd1);
      if (mem_we) begin
        if (waddr == START_A) begin
          check("start_wdata", mem_wdata, 32'd1);
          check("start_after_load", wr_idx, LW);
          start_wr++;
          exp_q.push_back(src_sum());
          exp_q.push_back(src[LW-1] + 32'd1);
        end else begin
          check("load_addr", 32'(waddr), wr_idx);
          check("load_data", mem_wdata, src[(wr_idx < LW) ? wr_idx : 0]);
          check("load_valid", 32'(in_valid & in_ready), 32'd1);
          wr_idx++;
        end
      end
      if (mem_re) begin
        if (raddr == DONE_A) begin
          check("poll_after_start", start_wr, 32'd1);
          poll_rd++;
        end else begin
          check("res_addr", 32'(raddr), LW + res_k);
          check("res_issue_idle", 32'(out_valid), 32'd0);
        end
      end
      if (p_valid && !p_ready) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, p_data);
      end
      if (out_valid && out_ready) begin
        check("res_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("res_data", out_data, exp_q.pop_front());
        got[got_n % 32] = out_data;
        got_n++;
        res_k++;
      end
      if (job_done) begin
        check("done_results", res_k, OP);
        check("done_single", 32'(p_done), 32'd0);
        last_writes = wr_idx;
        last_starts = start_wr;
        done_total++;
        wr_idx = 0; start_wr = 0; res_k = 0; poll_rd = 0;
      end
      if (error && !p_error) begin
        check("wd_polls", poll_rd, TO);
        check("wd_no_results", res_k, 32'd0);
        exp_q.delete();
        wr_idx = 0; start_wr = 0; res_k = 0; poll_rd = 0;
      end
      if (req == 1) begin
        check("pin_sum", got[0], 32'h0000_5AB4);
        check("pin_last", got[1], 32'd216);
      end
      if (req == 1 || req == 2) begin
        check("pin_writes", last_writes, LW);
        check("pin_starts", last_starts, 32'd1);
      end
`ifdef CONV3_SEQ_TIMEOUT_EN
      if (req == 3) check("wd_sticky_idle", 32'({error, busy, job_done}), 32'b100);
      if (req == 4) check("wd_cleared", 32'({error, busy}), 32'b01);
`endif
      if (req == 5) begin
        check("bounded_waits", tmo_cnt, 32'd0);
        check("jobs_done_total", done_total, jobs_exp);
      end
      p_valid = out_valid; p_ready = out_ready; p_data = out_data;
      p_done = job_done; p_error = error;
    end
  end

  task automatic request(input int r);
    req = r;
    @(negedge clk);
    #1 req = 0;
  endtask

  task automatic launch();
    @(posedge clk); #1 job_start = 1'b1;
    @(posedge clk); #1 job_start = 1'b0;
  endtask

  task automatic feed(input int vmode, input bit poke);
    int idx = 0;
    int cyc = 0;
    while (idx < LW && cyc < 4000) begin
      case (vmode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = src[idx];
      if (poke) job_start = (cyc % 7 == 3);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    job_start = 1'b0;
    if (idx < LW) tmo_cnt++;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!job_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!job_done) tmo_cnt++;
  endtask

  task automatic random_src();
    for (int i = 0; i < LW; i++) src[i] = $urandom;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Basic job with data = index, pinned against hand-computed results.
    for (int i = 0; i < LW; i++) src[i] = 32'(i);
    launch(); feed(0, 0); wait_done(300); jobs_exp++;
    request(1);

    // Input gaps 1010 plus ignored start pulses during LOAD.
    random_src();
    launch(); feed(1, 1); wait_done(300); jobs_exp++;
    request(2);

    // Output stall of 5 cycles on result 0.
    ready_mode = 2;
    random_src();
    launch(); feed(2, 0); wait_done(300); jobs_exp++;
    ready_mode = 0;

    // Asynchronous reset while polling.
    eng_delay = 40;
    random_src();
    launch(); feed(0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_re && raddr == DONE_A) && n < 300);
    if (n >= 300) tmo_cnt++;
    #2 rst_n = 1'b0;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    eng_delay = 6;

    // Job after reset restarts from address 0.
    random_src();
    launch(); feed(2, 0); wait_done(300); jobs_exp++;
    request(2);

    // Back-to-back jobs with random output backpressure.
    ready_mode = 1;
    random_src();
    launch(); feed(2, 0); wait_done(600); jobs_exp++;
    random_src();
    launch(); feed(2, 0); wait_done(600); jobs_exp++;
    ready_mode = 0;

`ifdef CONV3_SEQ_TIMEOUT_EN
    // Engine never reports done: watchdog aborts, then a fresh start clears the flag.
    eng_hang = 1'b1;
    random_src();
    launch(); feed(0, 0);
    n = 0;
    while (!error && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!error) tmo_cnt++;
    repeat (3) @(negedge clk);
    request(3);
    eng_hang = 1'b0;
    random_src();
    launch();
    request(4);
    feed(0, 0); wait_done(300); jobs_exp++;
`endif

    repeat (3) @(negedge clk);
    request(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
